// File: rtl/ysyx_23060236_ifu_pkg.sv
// Shared widths, reset vector, AXI response codes and state encoding for the NPC fetch unit.
package ysyx_23060236_ifu_pkg;

  localparam int unsigned ADDR_LEN = 32;
  localparam int unsigned DATA_LEN = 32;

  localparam logic [ADDR_LEN-1:0] RESET_PC = 32'h3000_0000;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    S_AR   = 2'd0,
    S_R    = 2'd1,
    S_HOLD = 2'd2
  } ifu_state_e;

endpackage

// File: rtl/ysyx_23060236_ifu.sv
// Instruction fetch unit: issues the PC over AXI4-Lite, pairs it with the BTB
// prediction and hands {inst, pc, pred} to decode; squashes wrong-path fetches.
module ysyx_23060236_ifu
  import ysyx_23060236_ifu_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  output logic [ADDR_LEN-1:0] btb_araddr,
  input  logic [ADDR_LEN-1:0] btb_rdata,
  output logic                ifu_arvalid,
  input  logic                ifu_arready,
  output logic [ADDR_LEN-1:0] ifu_araddr,
  input  logic                ifu_rvalid,
  output logic                ifu_rready,
  input  logic [DATA_LEN-1:0] ifu_rdata,
  input  logic [1:0]          ifu_rresp,
  output logic                inst_valid,
  input  logic                inst_ready,
  output logic [DATA_LEN-1:0] inst,
  output logic [ADDR_LEN-1:0] inst_pc,
  output logic [ADDR_LEN-1:0] inst_pred_pc,
  output logic                inst_fault,
  input  logic                redirect_valid,
  input  logic [ADDR_LEN-1:0] redirect_pc
);

  ifu_state_e          state;
  logic [ADDR_LEN-1:0] pc;
  logic [ADDR_LEN-1:0] pred_q;
  logic                drop;
  logic [ADDR_LEN-1:0] ar_q;

  // A redirect while AR is pending must not disturb the offered address, so
  // araddr is pinned to the pre-redirect PC until the handshake completes.
  assign ifu_araddr  = (state == S_AR && drop) ? ar_q : pc;
  assign btb_araddr  = pc;
  assign ifu_arvalid = (state == S_AR) && !reset;
  assign ifu_rready  = (state == S_R);
  assign inst_valid  = (state == S_HOLD);

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_AR;
      pc           <= RESET_PC;
      pred_q       <= '0;
      drop         <= 1'b0;
      ar_q         <= '0;
      inst         <= '0;
      inst_pc      <= '0;
      inst_pred_pc <= '0;
      inst_fault   <= 1'b0;
    end else begin
      unique case (state)
        S_AR: begin
          if (ifu_arready) begin
            pred_q <= btb_rdata;
            state  <= S_R;
          end
          if (redirect_valid) begin
            pc   <= redirect_pc;
            drop <= 1'b1;
            if (!ifu_arready && !drop) ar_q <= pc;
          end
        end
        S_R: begin
          if (ifu_rvalid) begin
            drop <= 1'b0;
            if (redirect_valid) begin
              pc    <= redirect_pc;
              state <= S_AR;
            end else if (drop) begin
              state <= S_AR;
            end else begin
              inst         <= ifu_rdata;
              inst_pc      <= pc;
              inst_pred_pc <= pred_q;
              inst_fault   <= (ifu_rresp != RESP_OKAY);
              pc           <= pred_q;
              state        <= S_HOLD;
            end
          end else if (redirect_valid) begin
            pc   <= redirect_pc;
            drop <= 1'b1;
          end
        end
        S_HOLD: begin
          if (redirect_valid) begin
            pc    <= redirect_pc;
            state <= S_AR;
          end else if (inst_ready) begin
            state <= S_AR;
          end
        end
        default: state <= S_AR;
      endcase
    end
  end

endmodule

// File: doc/ysyx_23060236_ifu.md
# ysyx_23060236_ifu

Instruction fetch unit of the NPC core, directly upstream of the branch target buffer. Holds the architectural fetch PC, presents it to the BTB for a next-PC prediction, fetches the instruction over an AXI4-Lite read channel, and hands {instruction, PC, predicted next PC} to the decode stage through a valid/ready handshake. Accepts redirects from the execute stage on misprediction and discards wrong-path fetches.

## Interface
- RESET_PC, 32'h3000_0000, PC fetched first after reset
- ADDR_LEN, 32, address width
- DATA_LEN, 32, instruction width

Ports:
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- btb_araddr  out  32  current fetch PC, combinational from the PC register
- btb_rdata  in  32  BTB predicted next PC for btb_araddr, combinational
- ifu_arvalid / ifu_arready  out / in  1  AR handshake
- ifu_araddr  out  32  fetch address (= PC)
- ifu_rvalid / ifu_rready  in / out  1  R handshake
- ifu_rdata  in  32  instruction word
- ifu_rresp  in  2  response; nonzero = access fault
- inst_valid / inst_ready  out / in  1  handshake to decode
- inst  out  32  instruction
- inst_pc  out  32  PC of inst
- inst_pred_pc  out  32  next PC predicted at fetch time
- inst_fault  out  1  rresp was nonzero
- redirect_valid  in  1  execute-stage misprediction
- redirect_pc  in  32  correct next PC

## Operation
- States: S_AR (arvalid=1), S_R (rready=1), S_HOLD (inst_valid=1). Reset → S_AR, pc=RESET_PC, drop=0.
- S_AR: araddr=pc. On arready: pred_q ← btb_rdata, → S_R.
- S_R: on rvalid: if drop, drop ← 0, → S_AR (no output); else latch rdata, pc → inst_pc, pred_q → inst_pred_pc, (rresp≠0) → inst_fault, pc ← pred_q, → S_HOLD.
- S_HOLD: on inst_ready → S_AR.
- Redirect, any state, highest priority: pc ← redirect_pc.
  - S_HOLD: buffered instruction discarded, → S_AR; an inst_ready in the same cycle does not count as a transfer (decode flushes too).
  - S_AR without arready: arvalid and araddr stay unchanged (AXI stability), drop ← 1.
  - S_AR with arready, or S_R without rvalid: drop ← 1 (outstanding read drained and discarded).
  - S_R with rvalid: returned data discarded, → S_AR with the new pc.
- A fault still advances pc to pred_q; the trap is taken in execute via redirect.
- pc and pred are full 32-bit; no alignment check in this block.

## Timing
- Reset outputs: ifu_arvalid=0, ifu_rready=0, inst_valid=0, inst_fault=0, inst/inst_pc/inst_pred_pc=0. ifu_arvalid=1 in the first cycle after reset deasserts.
- Zero-wait memory: AR accepted cycle t, rvalid at t+1, inst_valid at t+2. With inst_ready tied high, one instruction per 3 cycles.
- inst outputs stable while inst_valid=1 and inst_ready=0.
- btb_araddr changes only when pc updates; BTB lookup and AR issue share the cycle.
- Reset mid-transaction abandons it; the memory side must also reset.

## Structure
- Shared defines file: ADDR_LEN, DATA_LEN, RESET_PC, AXI resp codes (OKAY=2'b00), IFU state encoding.
- Single module with no sub-module. Registers: state, pc, pred_q, drop, output buffer.

## Test plan
- Reset, zero-wait memory, BTB miss (rdata=pc+4): fetches 0x3000_0000, 0x3000_0004, 0x3000_0008 in order, inst_pred_pc = inst_pc+4.
- BTB returns 0x3000_0100 for 0x3000_0004: next araddr = 0x3000_0100, inst_pred_pc = 0x3000_0100.
- inst_ready low 5 cycles: inst/inst_pc held, no new AR until transfer.
- redirect to 0x8000_0000 while arvalid=1, arready=0: araddr held until accepted, read data dropped, next araddr = 0x8000_0000, no inst_valid for dropped word.
- redirect coincident with inst_ready in S_HOLD: buffered word discarded, next fetch from redirect_pc.
- ifu_rresp=2'b10: inst_valid with inst_fault=1; next fetch from the predicted PC.
